// File: rtl/uart_pkg.sv
// Shared UART definitions: the receiver and the transmitter both use this state
// type and the default oversampling ratio.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } uart_state_t;

  localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus: serial input, per-frame parity enable, and the
// received-byte and status outputs.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
) ();

  logic                 parity_en;
  logic                 rx_uart;
  logic                 rx_data_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport slave (
    input  parity_en,
    input  rx_uart,
    output rx_data_valid,
    output rx_data,
    output parity_err,
    output frame_err,
    output busy
  );

  modport master (
    output parity_en,
    output rx_uart,
    input  rx_data_valid,
    input  rx_data,
    input  parity_err,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line, plus a delay stage
// used to detect a high-to-low transition on the synchronised bit.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_uart,
  output logic rx_s,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = rx_uart;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Flops reset to the idle-line level so reset release alone is no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rx_s = sync2_q;
  assign fall = prev_q & ~sync2_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampled UART receiver: start-bit validation, mid-bit sampling of
// LSB-first data, optional even parity, and stop-bit framing check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = 8
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .rx_uart (bus.rx_uart),
    .rx_s    (rx_s),
    .fall    (fall)
  );

  uart_state_t          state_q,   state_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic                 par_en_q,  par_en_d;
  logic                 par_bad_q, par_bad_d;
  logic [DATA_BITS-1:0] data_q,    data_d;
  logic                 valid_q,   valid_d;
  logic                 perr_q,    perr_d;
  logic                 ferr_q,    ferr_d;
  logic                 busy_q,    busy_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bad_d = par_bad_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF) begin
          if (!rx_s) begin
            state_d   = DATA;
            cnt_d     = '0;
            bit_cnt_d = '0;
            par_en_d  = bus.parity_en;
            par_bad_d = 1'b0;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          shift_d   = shift_q >> 1;
          shift_d[DATA_BITS-1] = rx_s;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = par_en_q ? PARITY : STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_bad_d = rx_s ^ (^shift_q);
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        // Leave at mid stop bit; the second half is idle time for resync.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          data_d  = shift_q;
          ferr_d  = ~rx_s;
          perr_d  = par_bad_q;
          valid_d = rx_s & ~par_bad_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bad_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bad_q <= par_bad_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.rx_data_valid = valid_q;
  assign bus.rx_data       = data_q;
  assign bus.parity_err    = perr_q;
  assign bus.frame_err     = ferr_q;
  assign bus.busy          = busy_q;

endmodule
